// File: rtl/pipe_mult.sv
// Pipelined signed/unsigned multiplier with a valid/ready handshake and a tag
// carried alongside each operation; each stage stalls independently.
module pipe_mult #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    input  logic                 Signed,
    input  logic [TAG_W-1:0]     Tag,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [2*WIDTH-1:0]   Result,
    output logic [TAG_W-1:0]     OutTag,
    output logic                 Busy
);

    localparam int PW = 2 * WIDTH;

    // Extending both operands to the product width makes a single modulo-2^PW
    // multiply exact for both signed and unsigned modes, including min*min.
    logic [PW-1:0] w_ext_a;
    logic [PW-1:0] w_ext_b;
    logic [PW-1:0] w_prod;

    assign w_ext_a = {{WIDTH{Signed & OpA[WIDTH-1]}}, OpA};
    assign w_ext_b = {{WIDTH{Signed & OpB[WIDTH-1]}}, OpB};
    assign w_prod  = w_ext_a * w_ext_b;

    logic [STAGES-1:0] r_valid;
    logic [PW-1:0]     r_prod [STAGES];
    logic [TAG_W-1:0]  r_tag  [STAGES];

    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_src_valid;
    logic [PW-1:0]     w_src_prod [STAGES];
    logic [TAG_W-1:0]  w_src_tag  [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign w_src_valid[gi] = InValid;
                assign w_src_prod[gi]  = w_prod;
                assign w_src_tag[gi]   = Tag;
            end else begin : g_rest
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_prod[gi]  = r_prod[gi-1];
                assign w_src_tag[gi]   = r_tag[gi-1];
            end
        end
    endgenerate

    // A stage may take new content when it is empty or its successor takes its own.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = ~r_valid[STAGES-1] | OutReady;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = ~r_valid[k] | w_load[k+1];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_prod[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    // Data only moves with a valid op, so Result stays 0 until the first result.
                    if (w_src_valid[k]) begin
                        r_prod[k] <= w_src_prod[k];
                        r_tag[k]  <= w_src_tag[k];
                    end
                end
            end
        end
    end

    assign InReady  = w_load[0];
    assign OutValid = r_valid[STAGES-1];
    assign Result   = r_prod[STAGES-1];
    assign OutTag   = r_tag[STAGES-1];
    assign Busy     = |r_valid;

endmodule

// File: tb/tb_pipe_mult.sv
// Self-checking bench: three pipe_mult configurations share one stimulus stream,
// each scored against an arithmetic reference product and a per-instance queue.
module tb_pipe_mult;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid;
    logic        OutReady;
    logic        Signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  Tag;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [31:0] res_a;
    logic [3:0]  otag_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [15:0] res_b;
    logic [3:0]  otag_b;
    logic        in_ready_c, out_valid_c, busy_c;
    logic [63:0] res_c;
    logic [3:0]  otag_c;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        int          cyc;
        int          stalls;
    } exp_t;

    exp_t q_exp [3][$];

    always #5 Clk = ~Clk;

    pipe_mult #(.WIDTH(16), .STAGES(3), .TAG_W(4)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_a),
        .OpA(op_a[15:0]), .OpB(op_b[15:0]), .Signed(Signed), .Tag(Tag),
        .OutValid(out_valid_a), .OutReady(OutReady), .Result(res_a),
        .OutTag(otag_a), .Busy(busy_a)
    );

    pipe_mult #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_b),
        .OpA(op_a[7:0]), .OpB(op_b[7:0]), .Signed(Signed), .Tag(Tag),
        .OutValid(out_valid_b), .OutReady(OutReady), .Result(res_b),
        .OutTag(otag_b), .Busy(busy_b)
    );

    pipe_mult #(.WIDTH(32), .STAGES(5), .TAG_W(4)) u_dut_c (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_c),
        .OpA(op_a), .OpB(op_b), .Signed(Signed), .Tag(Tag),
        .OutValid(out_valid_c), .OutReady(OutReady), .Result(res_c),
        .OutTag(otag_c), .Busy(busy_c)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        longint va, vb, p;
        logic [63:0] mask;
        mask = (64'h1 << w) - 64'h1;
        va = longint'(64'(a) & mask);
        vb = longint'(64'(b) & mask);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        p = va * vb;
        if (w < 32) return 64'(p) & ((64'h1 << (2 * w)) - 64'h1);
        return 64'(p);
    endfunction

    function automatic int width_of(input int id);
        case (id)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int stages_of(input int id);
        case (id)
            0:       return 3;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    task automatic mon_step(input int id, input logic in_ready, input logic out_valid,
                            input logic [63:0] result, input logic [3:0] otag);
        exp_t e;
        if (out_valid) begin
            if (q_exp[id].size() == 0) begin
                check($sformatf("dut%0d_spurious_out", id), 64'd1, 64'd0);
            end else begin
                e = q_exp[id][0];
                check($sformatf("dut%0d_result", id), result, e.res);
                check($sformatf("dut%0d_tag", id), 64'(otag), 64'(e.tag));
                if (OutReady) begin
                    if (e.stalls == stall_cnt)
                        check($sformatf("dut%0d_latency", id), 64'(cyc - e.cyc), 64'(stages_of(id)));
                    void'(q_exp[id].pop_front());
                    $display("txn dut%0d tag=%0h result=%0h", id, otag, result);
                end
            end
        end
        if (InValid && in_ready) begin
            e.res    = ref_mult(op_a, op_b, Signed, width_of(id));
            e.tag    = Tag;
            e.cyc    = cyc;
            e.stalls = stall_cnt;
            q_exp[id].push_back(e);
        end
    endtask

    always @(posedge Rst) begin
        for (int i = 0; i < 3; i++) q_exp[i].delete();
    end

    always @(negedge Clk) begin
        cyc++;
        if (!Rst) begin
            mon_step(0, in_ready_a, out_valid_a, 64'(res_a), otag_a);
            mon_step(1, in_ready_b, out_valid_b, 64'(res_b), otag_b);
            mon_step(2, in_ready_c, out_valid_c, res_c, otag_c);
            if (!OutReady) stall_cnt++;
        end
    end

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h0000_8000;
            2:       return 32'h0000_0080;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        InValid = 1'b1;
        op_a    = a;
        op_b    = b;
        Signed  = s;
        Tag     = t;
    endtask

    // One isolated 16-bit op with OutReady=1; valid must appear exactly 3 edges later for one cycle.
    task automatic single_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                             input logic [3:0] t, input logic [31:0] exp);
        @(posedge Clk); #1;
        drive({16'h0, a}, {16'h0, b}, s, t);
        check("single_ready", 64'(in_ready_a), 64'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            check($sformatf("single_valid_c%0d", i), 64'(out_valid_a), 64'(i == 3));
            if (i == 3) begin
                check("single_result", 64'(res_a), 64'(exp));
                check("single_tag", 64'(otag_a), 64'(t));
            end
        end
    endtask

    initial begin
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic        bs [4];

        Rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        op_a = '0; op_b = '0; Signed = 1'b0; Tag = '0;
        #3;
        check("rst_outvalid", 64'(out_valid_a), 64'd0);
        check("rst_result", 64'(res_a), 64'd0);
        check("rst_outtag", 64'(otag_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_inready", 64'(in_ready_a), 64'd1);
        check("rst_inready_s1", 64'(in_ready_b), 64'd1);
        check("rst_outvalid_s5", 64'(out_valid_c), 64'd0);
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b0;

        single_op(16'hFFFF, 16'hFFFF, 1'b0, 4'h5, 32'hFFFE_0001);
        single_op(16'hFFFF, 16'h0002, 1'b1, 4'h1, 32'hFFFF_FFFE);
        single_op(16'h8000, 16'h8000, 1'b1, 4'h2, 32'h4000_0000);
        single_op(16'h8000, 16'h7FFF, 1'b1, 4'h3, 32'hC000_8000);
        single_op(16'hFFFF, 16'h0002, 1'b0, 4'h4, 32'h0001_FFFE);

        // Streaming: ten back-to-back ops, tags 0..9.
        @(posedge Clk); #1;
        drive({16'h0, 16'($urandom)}, {16'h0, 16'($urandom)}, 1'($urandom), 4'd0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge Clk); #1;
            if (i < 10) drive({16'h0, 16'($urandom)}, {16'h0, 16'($urandom)}, 1'($urandom), 4'(i));
            else InValid = 1'b0;
            @(negedge Clk);
            check($sformatf("stream_valid_c%0d", i), 64'(out_valid_a), 64'(i >= 3 && i <= 12));
            check($sformatf("stream_busy_c%0d", i), 64'(busy_a), 64'(i <= 12));
            if (i >= 3 && i <= 12) check($sformatf("stream_tag_c%0d", i), 64'(otag_a), 64'(i - 3));
            if (i < 10) check($sformatf("stream_ready_c%0d", i), 64'(in_ready_a), 64'd1);
        end

        // Backpressure: four ops offered with OutReady=0, only three fit.
        for (int k = 0; k < 4; k++) begin
            ba[k] = {16'h0, 16'($urandom)};
            bb[k] = {16'h0, 16'($urandom)};
            bs[k] = 1'($urandom);
        end
        @(posedge Clk); #1;
        OutReady = 1'b0;
        drive(ba[0], bb[0], bs[0], 4'd1);
        for (int k = 1; k < 4; k++) begin
            @(posedge Clk); #1;
            drive(ba[k], bb[k], bs[k], 4'(k + 1));
        end
        for (int h = 0; h < 2; h++) begin
            if (h > 0) @(posedge Clk);
            @(negedge Clk);
            check("bp_inready_full", 64'(in_ready_a), 64'd0);
            check("bp_outvalid_held", 64'(out_valid_a), 64'd1);
            check("bp_tag_held", 64'(otag_a), 64'd1);
            check("bp_result_held", 64'(res_a), ref_mult(ba[0], bb[0], bs[0], 16));
            check("bp_busy", 64'(busy_a), 64'd1);
        end
        @(posedge Clk); #1;
        OutReady = 1'b1;
        #1 check("bp_inready_release", 64'(in_ready_a), 64'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge Clk);
            check($sformatf("bp_drain_valid%0d", j), 64'(out_valid_a), 64'(j < 3));
            if (j < 3) begin
                check($sformatf("bp_drain_tag%0d", j), 64'(otag_a), 64'(j + 2));
                check($sformatf("bp_drain_res%0d", j), 64'(res_a), ref_mult(ba[j + 1], bb[j + 1], bs[j + 1], 16));
            end
            @(posedge Clk);
        end
        repeat (4) @(posedge Clk);

        // Reset mid-flight: two ops inside, async pulse between edges.
        #1 drive(32'h0000_1234, 32'h0000_5678, 1'b0, 4'd7);
        @(posedge Clk); #1;
        drive(32'h0000_9ABC, 32'h0000_DEF0, 1'b1, 4'd8);
        @(posedge Clk); #1;
        InValid = 1'b0;
        #1 Rst = 1'b1;
        #1;
        check("midrst_outvalid", 64'(out_valid_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_result", 64'(res_a), 64'd0);
        check("midrst_inready", 64'(in_ready_a), 64'd1);
        check("midrst_busy_s5", 64'(busy_c), 64'd0);
        Rst = 1'b0;
        drive(32'h0000_0003, 32'h0000_0005, 1'b0, 4'd9);
        check("postrst_inready", 64'(in_ready_a), 64'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            check($sformatf("postrst_valid_c%0d", i), 64'(out_valid_a), 64'(i == 3));
            if (i == 3) begin
                check("postrst_tag", 64'(otag_a), 64'd9);
                check("postrst_result", 64'(res_a), 64'd15);
            end
        end

        // Random phase: random backpressure first, then OutReady held high for exact latency.
        for (int n = 0; n < 600; n++) begin
            @(posedge Clk); #1;
            InValid  = ($urandom_range(0, 3) != 0);
            op_a     = pick_op();
            op_b     = pick_op();
            Signed   = 1'($urandom);
            Tag      = 4'(n);
            OutReady = (n < 300) ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
        @(posedge Clk); #1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        repeat (10) @(posedge Clk);
        @(negedge Clk); #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d_all_drained", i), 64'(q_exp[i].size()), 64'd0);
        check("final_busy", 64'(busy_a | busy_b | busy_c), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_mult.md
PIPE_MULT -- requirements
Module: pipe_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter STAGES, default 3, giving the pipeline depth (legal range 1..8).
REQ-003 The block SHALL have parameter TAG_W, default 4, giving the width of the sideband tag carried with each operation.
REQ-004 Clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 Rst  in  1  reset; asynchronous, active-high.
REQ-006 InValid  in  1  the upstream operand pair is valid.
REQ-007 InReady  out  1  the block accepts an operand pair this cycle.
REQ-008 OpA  in  WIDTH  multiplicand.
REQ-009 OpB  in  WIDTH  multiplier.
REQ-010 Signed  in  1  1 = two's-complement operands; 0 = unsigned operands; sampled with the operands.
REQ-011 Tag  in  TAG_W  sideband ID; returned unchanged with the result.
REQ-012 OutValid  out  1  Result and OutTag are valid.
REQ-013 OutReady  in  1  downstream consumes the result this cycle.
REQ-014 Result  out  2*WIDTH  product.
REQ-015 OutTag  out  TAG_W  tag of the operation presented on Result.
REQ-016 Busy  out  1  at least one pipeline stage holds a valid operation.

Function
REQ-017 An operation SHALL be accepted on a rising edge where InValid=1 and InReady=1; it SHALL be captured together with its Signed and Tag values.
REQ-018 The pipeline SHALL consist of STAGES registered stages; each stage SHALL carry a valid bit, a partial or final product, and a tag.
REQ-019 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage SHALL advance when OutReady=1 or OutValid=0.
REQ-020 InReady SHALL equal (stage 0 empty) OR (stage 0 advancing); InReady SHALL be combinational from OutReady through the stall chain.
REQ-021 With OutReady held at 1, an operation accepted at edge N SHALL present OutValid=1 with its result after edge N+STAGES-1, giving a latency of STAGES cycles.
REQ-022 Sustained throughput SHALL be one operation per cycle with no bubbles while OutReady=1.
REQ-023 A stalled stage SHALL hold its product, tag and valid bit unchanged; Result and OutTag SHALL stay stable while OutValid=1 and OutReady=0.
REQ-024 Unsigned mode SHALL produce the exact 2*WIDTH-bit zero-extended product.
REQ-025 Signed mode SHALL produce the exact 2*WIDTH-bit two's-complement product, including for the case (-2^(WIDTH-1)) * (-2^(WIDTH-1)).
REQ-026 Multiplication work MAY be distributed across stages; the final Result SHALL be independent of how it is distributed.
REQ-027 Operations SHALL exit in acceptance order; no operation SHALL be dropped or duplicated.
REQ-028 When the pipeline is full and OutReady=1, an input SHALL be accepted in the same cycle that the output drains.
REQ-029 With STAGES=1, OutValid SHALL assert the cycle after acceptance, and InReady SHALL equal (NOT OutValid) OR OutReady.
REQ-030 Busy SHALL be the OR of all stage valid bits.
REQ-031 Result and OutTag SHALL be don't-care while OutValid=0, but SHALL read 0 after reset until the first result is produced.

Reset
REQ-032 Rst=1 SHALL immediately clear all stage valid bits, products and tags to 0, regardless of Clk.
REQ-033 During reset, OutValid=0, Result=0, OutTag=0, Busy=0 and InReady=1 SHALL hold.
REQ-034 Operations in flight when Rst asserts SHALL be discarded and SHALL never appear on the output.
REQ-035 The first edge after Rst deasserts SHALL be able to accept an operation.

Verification (WIDTH=16, STAGES=3, TAG_W=4 unless stated)
REQ-036 Unsigned: OpA=0xFFFF, OpB=0xFFFF, Tag=0x5, Signed=0, OutReady=1 -> three cycles later Result=0xFFFE0001, OutTag=0x5, with OutValid=1 for exactly one cycle.
REQ-037 Signed: 0xFFFF*0x0002 -> 0xFFFFFFFE; 0x8000*0x8000 -> 0x40000000; 0x8000*0x7FFF -> 0xC0008000; the same 0xFFFF*0x0002 with Signed=0 -> 0x0001FFFE.
REQ-038 Streaming: 10 back-to-back operations with tags 0..9 and OutReady=1 -> 10 consecutive OutValid cycles, tags in order 0..9, and all results correct.
REQ-039 Backpressure: OutReady=0 while 4 operations are offered -> 3 accepted, InReady=0 on the 4th, Result held stable; OutReady=1 -> the held results drain in order and the 4th operation is accepted in the same cycle.
REQ-040 Reset mid-flight: 2 operations in flight, then Rst pulsed asynchronously between edges -> OutValid=0 and Busy=0 immediately, and neither result ever appears.
REQ-041 Parameter sweep: WIDTH=8 with STAGES=1, and WIDTH=32 with STAGES=5, run against random signed and unsigned operands -> results match the reference product with latency equal to STAGES.
